// File: rtl/call_stack_pkg.sv
// ---------------------------------------------------------------
// call_stack_pkg : shared types and helpers for call_stack_p
// Revision 1.0
// ---------------------------------------------------------------
`default_nettype none

package call_stack_pkg;

   typedef enum logic {
      OVF_DROP = 1'b0,
      OVF_WRAP = 1'b1
   } ovf_mode_t;

   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/call_stack_p.sv
// ---------------------------------------------------------------
// call_stack_p : return-address stack with count, status and
//                sticky error flags, selectable overflow policy
// Revision 1.0
// ---------------------------------------------------------------
`default_nettype none

module call_stack_p
   import call_stack_pkg::*;
#(
   parameter int        WIDTH    = 12,
   parameter int        DEPTH    = 8,
   parameter ovf_mode_t OVF_MODE = OVF_DROP,
   localparam int       CW       = cnt_width(DEPTH),
   localparam int       PW       = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   input  logic             clear,
   output logic [WIDTH-1:0] top,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty,
   output logic             ovf,
   output logic             unf
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    ptr_q, ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             we;
   logic [PW-1:0]    waddr;
   logic [PW-1:0]    ptr_inc, ptr_dec;

   // Explicit wrap so non-power-of-two depths stay inside the array.
   assign ptr_inc = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
   assign ptr_dec = (ptr_q == '0) ? PW'(DEPTH - 1) : ptr_q - 1'b1;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign ovf   = ovf_q;
   assign unf   = unf_q;
   assign top   = empty ? '0 : mem_q[ptr_dec];

   always_comb begin
      ptr_d   = ptr_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      we      = 1'b0;
      waddr   = ptr_q;
      if (clear) begin
         ptr_d   = '0;
         count_d = '0;
         ovf_d   = 1'b0;
         unf_d   = 1'b0;
      end else if (push && pop) begin
         if (empty) begin
            we      = 1'b1;
            ptr_d   = ptr_inc;
            count_d = CW'(1);
            unf_d   = 1'b1;
         end else begin
            we    = 1'b1;
            waddr = ptr_dec;
         end
      end else if (push) begin
         if (!full) begin
            we      = 1'b1;
            ptr_d   = ptr_inc;
            count_d = count_q + 1'b1;
         end else begin
            ovf_d = 1'b1;
            if (OVF_MODE == OVF_WRAP) begin
               we    = 1'b1;
               ptr_d = ptr_inc;
            end
         end
      end else if (pop) begin
         if (empty) begin
            unf_d = 1'b1;
         end else begin
            ptr_d   = ptr_dec;
            count_d = count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         ptr_q   <= ptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= push_data;
      end
   end

endmodule

`default_nettype wire
